// File: rtl/mux_iord_reg.sv
// Purpose: latch one of N_CH address channels on request, hold a memory handshake until ack or timeout.
// Latency: mem_req from the acceptance edge; done one cycle after the ack/timeout edge (min 2 cycles req-to-done).
// Backpressure: requests arriving while busy are dropped (no queuing); a held req re-arms right after DONE.
module mux_iord_reg #(
    parameter int WIDTH   = 32,
    parameter int N_CH    = 5,   // legal 2..8
    parameter int SEL_W   = 3,   // 2**SEL_W must cover N_CH
    parameter int TIMEOUT = 8    // legal 2..255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_CH*WIDTH-1:0]  canais,
    input  logic [SEL_W-1:0]       escolha,
    input  logic                   req,
    input  logic                   mem_ack,
    output logic [WIDTH-1:0]       endereco,
    output logic                   mem_req,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic                   sel_erro
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter value seen on the last allowed wait cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       wait_cnt;
    logic             accept;
    logic             to_end;
    logic             sel_bad;
    logic [WIDTH-1:0] sel_dat;

    // Channel selection; out-of-range selects fall back to the last channel.
    always_comb begin
        sel_bad = (int'(escolha) >= N_CH);
        sel_dat = canais[(N_CH-1)*WIDTH +: WIDTH];
        for (int k = 0; k < N_CH; k++) begin
            if (escolha == SEL_W'(k)) begin
                sel_dat = canais[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic; ack takes priority over the timeout on the same cycle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        to_end    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_nxt = S_DONE;
                end else if (wait_cnt == CNT_LAST) begin
                    to_end    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Address/flag capture at acceptance and wait counting while in REQ.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            endereco <= '0;
            sel_erro <= 1'b0;
            timeout  <= 1'b0;
            wait_cnt <= 8'd0;
        end else begin
            if (accept) begin
                endereco <= sel_dat;
                sel_erro <= sel_bad;
                timeout  <= 1'b0;
                wait_cnt <= 8'd0;
            end else if (state == S_REQ && !mem_ack) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (to_end) begin
                timeout <= 1'b1;
            end
        end
    end

    // Handshake outputs are pure state decodes.
    assign mem_req = (state == S_REQ);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_mux_iord_reg.sv
// Purpose: directed check of mux_iord_reg against a transaction-level reference model.
// Latency: model updates on each rising edge; outputs compared on every falling edge.
// Backpressure: none in the bench; req/mem_ack are driven directly.
module tb_mux_iord_reg;

    localparam int WIDTH   = 32;
    localparam int N_CH    = 5;
    localparam int SEL_W   = 3;
    localparam int TIMEOUT = 8;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b1;
    logic [N_CH*WIDTH-1:0] canais = '0;
    logic [SEL_W-1:0]      escolha = '0;
    logic                  req = 1'b0;
    logic                  mem_ack = 1'b0;
    logic [WIDTH-1:0]      endereco;
    logic                  mem_req;
    logic                  busy;
    logic                  done;
    logic                  timeout;
    logic                  sel_erro;

    int n_chk  = 0;
    int n_pass = 0;

    mux_iord_reg #(
        .WIDTH  (WIDTH),
        .N_CH   (N_CH),
        .SEL_W  (SEL_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .canais  (canais),
        .escolha (escolha),
        .req     (req),
        .mem_ack (mem_ack),
        .endereco(endereco),
        .mem_req (mem_req),
        .busy    (busy),
        .done    (done),
        .timeout (timeout),
        .sel_erro(sel_erro)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 waiting on memory, 2 completion.
    int               m_phase = 0;
    int               m_cycles = 0;   // REQ cycles elapsed in the current access
    int               m_ch = 0;
    logic [WIDTH-1:0] m_addr = '0;
    logic             m_to = 1'b0;
    logic             m_se = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_cycles = 0; m_addr = '0; m_to = 1'b0; m_se = 1'b0;
        end else begin
            if (m_phase == 0) begin
                if (req) begin
                    m_ch = int'(escolha);
                    m_se = (m_ch >= N_CH);
                    if (m_se) m_ch = N_CH - 1;
                    m_addr   = canais[m_ch*WIDTH +: WIDTH];
                    m_to     = 1'b0;
                    m_cycles = 0;
                    m_phase  = 1;
                end
            end else if (m_phase == 1) begin
                m_cycles = m_cycles + 1;
                if (mem_ack) begin
                    m_phase = 2;
                end else if (m_cycles == TIMEOUT) begin
                    m_to    = 1'b1;
                    m_phase = 2;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    // Per-cycle compare plus pulse counters used by the scenario checks.
    int   n_mr = 0;
    int   n_dn = 0;
    logic d_to = 1'b0;
    logic d_se = 1'b0;

    always @(negedge clk) begin
        logic e_mr, e_busy, e_done;
        e_mr   = (m_phase == 1);
        e_busy = (m_phase != 0);
        e_done = (m_phase == 2);
        n_chk = n_chk + 1;
        if (endereco === m_addr && mem_req === e_mr && busy === e_busy &&
            done === e_done && timeout === m_to && sel_erro === m_se) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL cycle t=%0t: got end=%h mr=%b busy=%b done=%b to=%b se=%b, want end=%h mr=%b busy=%b done=%b to=%b se=%b",
                     $time, endereco, mem_req, busy, done, timeout, sel_erro,
                     m_addr, e_mr, e_busy, e_done, m_to, m_se);
        end
        if (mem_req) n_mr = n_mr + 1;
        if (done) begin
            n_dn = n_dn + 1;
            d_to = timeout;
            d_se = sel_erro;
        end
    end

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One access: select sel, assert ack on REQ cycle ack_at (0 = never).
    // Inputs are scrambled after acceptance to show the address is held.
    task automatic access(input int sel, input int ack_at);
        logic [N_CH*WIDTH-1:0] saved;
        n_mr = 0; n_dn = 0; d_to = 1'bx; d_se = 1'bx;
        escolha = SEL_W'(sel);
        req = 1'b1;
        step();
        req = 1'b0;
        saved = canais;
        canais = ~canais;
        escolha = ~escolha;
        for (int c = 1; c <= TIMEOUT + 2; c++) begin
            mem_ack = (c == ack_at);
            step();
        end
        mem_ack = 1'b0;
        canais = saved;
        step();
    endtask

    initial begin
        canais[0*WIDTH +: WIDTH] = 32'h1111_0000;
        canais[1*WIDTH +: WIDTH] = 32'hAAAA_5555;
        canais[2*WIDTH +: WIDTH] = 32'h0000_1234;
        canais[3*WIDTH +: WIDTH] = 32'h3333_3333;
        canais[4*WIDTH +: WIDTH] = 32'hDEAD_BEEF;

        #1 reset_n = 1'b0;
        #11;
        chk("reset_endereco", endereco, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_flags", {29'b0, done, timeout, sel_erro}, 32'h0);
        #10 reset_n = 1'b1;
        step();

        // Normal access to channel 2, ack on the 3rd REQ cycle.
        access(2, 3);
        chk("s1_endereco", endereco, 32'h0000_1234);
        chk("s1_mem_req_cycles", n_mr, 3);
        chk("s1_done_pulses", n_dn, 1);
        chk("s1_timeout", {31'b0, d_to}, 32'h0);
        chk("s1_sel_erro", {31'b0, d_se}, 32'h0);

        // Out-of-range select falls back to channel 4 and flags it.
        access(6, 1);
        chk("s2_endereco", endereco, 32'hDEAD_BEEF);
        chk("s2_sel_erro", {31'b0, d_se}, 32'h1);
        chk("s2_mem_req_cycles", n_mr, 1);
        access(0, 1);
        chk("s2b_sel_erro", {31'b0, sel_erro}, 32'h0);
        chk("s2b_endereco", endereco, 32'h1111_0000);

        // No ack: timeout after exactly TIMEOUT REQ cycles.
        access(3, 0);
        chk("s3_mem_req_cycles", n_mr, 8);
        chk("s3_timeout", {31'b0, d_to}, 32'h1);
        chk("s3_endereco", endereco, 32'h3333_3333);
        chk("s3_done_pulses", n_dn, 1);

        // Ack on the last allowed cycle beats the timeout.
        access(1, 8);
        chk("s4_mem_req_cycles", n_mr, 8);
        chk("s4_timeout", {31'b0, d_to}, 32'h0);
        chk("s4_endereco", endereco, 32'hAAAA_5555);

        // Reset in the 2nd REQ cycle aborts the access.
        n_mr = 0; n_dn = 0;
        escolha = 3'd4; req = 1'b1;
        step();
        req = 1'b0;
        step();
        #1 reset_n = 1'b0;
        #1;
        chk("s5_async_endereco", endereco, 32'h0);
        chk("s5_async_ctrl", {30'b0, mem_req, busy}, 32'h0);
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("s5_no_done", n_dn, 0);
        access(2, 2);
        chk("s5_fresh_done", n_dn, 1);
        chk("s5_fresh_endereco", endereco, 32'h0000_1234);

        // Held req with constant ack: IDLE/REQ/DONE repeating.
        n_mr = 0; n_dn = 0;
        req = 1'b1; mem_ack = 1'b1; escolha = 3'd1;
        step();
        for (int i = 0; i < 8; i++) begin
            escolha = SEL_W'(i + 2);
            step();
        end
        req = 1'b0; mem_ack = 1'b0;
        step();
        step();
        chk("s6_done_pulses", n_dn, 3);
        chk("s6_mem_req_cycles", n_mr, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
